ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Fetch-stage controller between the PC and the instruction bus.
- Generates the single-outstanding instruction request and captures returned instructions into a one-entry fetch slot for decode.
- Produces i_wait toward the hazard unit, and obeys stall_f (stallF) and redirect (branch/exception target) from it.
- In-flight requests invalidated by a redirect are drained and discarded.

Parameters:
PC_RESET, 64'h0000_0000_8000_0000, PC after reset
ADDR_W, 64, PC / request address width
INSN_W, 32, instruction width

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
stall_f  in  1  hazard stall; when 1, fetch slot not consumed this cycle
redirect_valid  in  1  one-cycle pulse: discard everything, refetch from redirect_pc
redirect_pc  in  ADDR_W  redirect target, bits[1:0] must be 0
ireq_valid  out  1  request valid
ireq_addr  out  ADDR_W  request address
ireq_addr_ok  in  1  request accepted this cycle
iresp_data_ok  in  1  response data valid this cycle
iresp_data  in  INSN_W  response instruction
inst_valid  out  1  fetch slot holds a valid instruction
inst_pc  out  ADDR_W  PC of slot instruction
inst_data  out  INSN_W  slot instruction
i_wait  out  1  fetch cannot supply an instruction this cycle

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, pc=PC_RESET.
  - inst_valid=0, inst_pc=0, inst_data=0.
  - ireq_valid=0, i_wait=0.
  - Reset mid-transaction abandons it; the bus is also reset.
- States and transitions:
  - IDLE: next cycle -> REQ.
  - REQ: ireq_valid = can_issue, where can_issue = !inst_valid || !stall_f. ireq_addr = pc. ireq_valid && ireq_addr_ok -> WAIT.
  - WAIT: on iresp_data_ok, write slot (inst_valid=1, inst_pc=pc, inst_data=iresp_data), pc<=pc+4, -> REQ. All of these take effect the next cycle.
  - DROP: stale request outstanding. On iresp_data_ok, discard the data, -> REQ. pc already holds the redirect target.
- Bus rules:
  - Once ireq_valid=1, ireq_valid and ireq_addr stay stable until ireq_addr_ok, even across redirect or stall.
  - At most one request is outstanding.
  - iresp_data_ok is ignored in IDLE/REQ.
- Slot consumption: slot is consumed on any cycle with inst_valid && !stall_f. inst_valid clears next cycle unless refilled the same cycle.
- can_issue guarantees the slot is empty when data returns, so no skid buffer is needed.
- Fetch latency: addr_ok at cycle t, data_ok at t+k, inst_valid at t+k+1. Minimum 2 cycles from issue to slot.
- Redirect (highest priority; same-cycle stall_f is irrelevant):
  - pc<=redirect_pc and inst_valid<=0 (slot flushed).
  - REQ with no valid / no addr_ok: stay REQ, next issue uses new pc.
  - REQ with ireq_valid=1 but not accepted: set drop_pending. That request must stay stable, so on its addr_ok -> DROP, not WAIT.
  - REQ with ireq_addr_ok the same cycle -> DROP.
  - WAIT without data_ok -> DROP. WAIT with data_ok the same cycle -> data discarded, -> REQ.
  - DROP: stay DROP (latest redirect_pc wins). If data_ok the same cycle -> REQ.
  - IDLE: pc<=redirect_pc, -> REQ.
- i_wait = !inst_valid && state!=IDLE (combinational).
- Arithmetic: pc+4 is modulo 2^ADDR_W; wrap silently.
- redirect_pc[1:0]!=0 is illegal; a simulation assertion fires, and low bits are forced to 0.

Test Plan:
1. Reset release, bus addr_ok same cycle, data_ok 1 cycle later with 32'h00000013. Required: ireq_addr=0x80000000; inst_valid=1, inst_pc=0x80000000 next; next request addr 0x80000004; i_wait=1 until slot fills.
2. Slot valid with stall_f=1 for 3 cycles. Required: ireq_valid=0, inst_* held constant; after stall_f drops, request 0x80000004 issues the same cycle.
3. redirect_valid to 0x80001000 while in WAIT; data_ok 2 cycles later with 32'hDEADBEEF. Required: data never appears in slot; next ireq_addr=0x80001000.
4. redirect to 0x80002000 in the same cycle as data_ok in WAIT. Required: data dropped, inst_valid=0, next request 0x80002000, no DROP state.
5. ireq_valid held with addr_ok=0 for 4 cycles, then redirect to 0x80003000. Required: ireq_addr stays at the old value until accepted; its response is discarded; next request 0x80003000.
6. Back-to-back redirects 0x100 then 0x200 while in DROP. Required: single stale response discarded; next request 0x200; pc=0xFFFF_FFFF_FFFF_FFFC fetch wraps to 0x0.

Source files
------------

// File: rtl/ifetch_ctrl_if.sv
// Instruction bus between the fetch controller (master) and the instruction memory (slave).
// Request channel: valid/addr with addr_ok accept; response channel: data_ok/data.
interface ifetch_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int INSN_W = 32
);
  logic              ireq_valid;
  logic [ADDR_W-1:0] ireq_addr;
  logic              ireq_addr_ok;
  logic              iresp_data_ok;
  logic [INSN_W-1:0] iresp_data;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  ireq_addr_ok,
    input  iresp_data_ok,
    input  iresp_data
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output ireq_addr_ok,
    output iresp_data_ok,
    output iresp_data
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// Fetch-stage controller: single-outstanding instruction request, one-entry fetch slot,
// redirect handling with draining of stale in-flight requests.
module ifetch_ctrl #(
  parameter int                ADDR_W   = 64,
  parameter int                INSN_W   = 32,
  parameter logic [ADDR_W-1:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              stall_f,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  ifetch_ctrl_if.master     bus,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [INSN_W-1:0] inst_data,
  output logic              i_wait
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [ADDR_W-1:0] r_pc;
  logic              r_hold;
  logic [ADDR_W-1:0] r_hold_addr;
  logic              r_drop_pend;
  logic              r_inst_valid;
  logic [ADDR_W-1:0] r_inst_pc;
  logic [INSN_W-1:0] r_inst_data;

  logic [ADDR_W-1:0] w_redir_pc;
  logic              w_can_issue;
  logic              w_ireq_valid;
  logic [ADDR_W-1:0] w_ireq_addr;
  logic              w_req_fire;
  logic              w_fill;

  assign w_redir_pc  = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign w_can_issue = !r_inst_valid || !stall_f;
  assign w_req_fire  = w_ireq_valid && bus.ireq_addr_ok;
  assign w_fill      = (r_state == S_WAIT) && bus.iresp_data_ok && !redirect_valid;

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a request already presented when a redirect hit still lands in DROP
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_req_fire) begin
          w_state_nxt = (redirect_valid || r_drop_pend) ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.iresp_data_ok) begin
          w_state_nxt = S_REQ;
        end else if (redirect_valid) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (bus.iresp_data_ok) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: a held request keeps its original address even after pc moves
  always_comb begin
    w_ireq_valid = 1'b0;
    w_ireq_addr  = r_pc;
    if (r_state == S_REQ) begin
      w_ireq_valid = r_hold || w_can_issue;
      if (r_hold) begin
        w_ireq_addr = r_hold_addr;
      end
    end
  end

  assign bus.ireq_valid = w_ireq_valid;
  assign bus.ireq_addr  = w_ireq_addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pc        <= PC_RESET;
      r_hold      <= 1'b0;
      r_hold_addr <= '0;
      r_drop_pend <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_pc <= w_redir_pc;
      end else if (w_fill) begin
        r_pc <= r_pc + ADDR_W'(4);
      end
      r_hold <= w_ireq_valid && !bus.ireq_addr_ok;
      if (w_ireq_valid) begin
        r_hold_addr <= w_ireq_addr;
      end
      r_drop_pend <= w_ireq_valid && !bus.ireq_addr_ok && (r_drop_pend || redirect_valid);
    end
  end

  // Fetch slot: flush beats refill beats consume
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inst_valid <= 1'b0;
      r_inst_pc    <= '0;
      r_inst_data  <= '0;
    end else begin
      if (redirect_valid) begin
        r_inst_valid <= 1'b0;
      end else if (w_fill) begin
        r_inst_valid <= 1'b1;
        r_inst_pc    <= r_pc;
        r_inst_data  <= bus.iresp_data;
      end else if (r_inst_valid && !stall_f) begin
        r_inst_valid <= 1'b0;
      end
    end
  end

  assign inst_valid = r_inst_valid;
  assign inst_pc    = r_inst_pc;
  assign inst_data  = r_inst_data;
  assign i_wait     = !r_inst_valid && (r_state != S_IDLE);

  a_redirect_aligned: assert property (@(posedge clk) disable iff (!resetn)
    redirect_valid |-> (redirect_pc[1:0] == 2'b00));

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios then random stimulus against a transaction-level model.
module tb_ifetch_ctrl;
  localparam int          ADDR_W = 64;
  localparam int          INSN_W = 32;
  localparam logic [63:0] PC_RST = 64'h0000_0000_8000_0000;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              stall_f = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_pc;
  logic [INSN_W-1:0] inst_data;
  logic              i_wait;

  ifetch_ctrl_if #(.ADDR_W(ADDR_W), .INSN_W(INSN_W)) bus ();

  ifetch_ctrl #(.ADDR_W(ADDR_W), .INSN_W(INSN_W), .PC_RESET(PC_RST)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .stall_f        (stall_f),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .inst_valid     (inst_valid),
    .inst_pc        (inst_pc),
    .inst_data      (inst_data),
    .i_wait         (i_wait)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Transaction-level model: presented request, outstanding request, fetch slot
  bit          m_started, m_slot_v, m_pres, m_pres_stale, m_out, m_out_stale;
  logic [63:0] m_pc, m_slot_pc, m_pres_addr, m_out_addr;
  logic [31:0] m_slot_data;
  int          m_lat;
  logic        o_v;
  logic [63:0] o_a;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  task automatic model_reset();
    m_started = 0; m_slot_v = 0; m_pres = 0; m_pres_stale = 0; m_out = 0; m_out_stale = 0;
    m_pc = PC_RST; m_slot_pc = '0; m_slot_data = '0; m_pres_addr = '0; m_out_addr = '0;
    m_lat = 0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; stall_f = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    bus.ireq_addr_ok = 1'b0; bus.iresp_data_ok = 1'b0; bus.iresp_data = '0;
    #1;
    chk("rst_ireq_valid", 64'(bus.ireq_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_inst_pc", inst_pc, 64'd0);
    chk("rst_inst_data", 64'(inst_data), 64'd0);
    chk("rst_i_wait", 64'(i_wait), 64'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
  endtask

  // Called at posedge+1: drive one cycle of inputs, compare outputs, advance the model
  task automatic step(input logic st, input logic rv, input logic [63:0] rp,
                      input logic aok, input logic dok, input logic [31:0] dat);
    logic        exp_v, acc, resp;
    logic [63:0] exp_a;
    stall_f = st; redirect_valid = rv; redirect_pc = rp;
    bus.ireq_addr_ok = aok; bus.iresp_data_ok = dok; bus.iresp_data = dat;
    #1;
    exp_v = m_started && !m_out && (m_pres || !m_slot_v || !st);
    exp_a = m_pres ? m_pres_addr : m_pc;
    o_v = bus.ireq_valid;
    o_a = bus.ireq_addr;
    chk("ireq_valid", 64'(o_v), 64'(exp_v));
    if (exp_v) chk("ireq_addr", o_a, exp_a);
    chk("inst_valid", 64'(inst_valid), 64'(m_slot_v));
    chk("inst_pc", inst_pc, m_slot_pc);
    chk("inst_data", 64'(inst_data), 64'(m_slot_data));
    chk("i_wait", 64'(i_wait), 64'(m_started && !m_slot_v));
    acc  = exp_v && aok;
    resp = m_out && dok;
    if (!m_started) begin
      m_started = 1;
      if (rv) m_pc = rp & ~64'h3;
    end else begin
      if (resp) begin
        m_out = 0;
        if (!m_out_stale && !rv) begin
          m_slot_v = 1; m_slot_pc = m_out_addr; m_slot_data = dat; m_pc = m_out_addr + 64'd4;
        end
      end else if (m_slot_v && !st) begin
        m_slot_v = 0;
      end
      if (acc) begin
        m_out = 1; m_out_addr = exp_a; m_out_stale = m_pres_stale || rv;
        m_pres = 0; m_pres_stale = 0; m_lat = $urandom_range(0, 3);
      end else if (exp_v) begin
        m_pres = 1; m_pres_addr = exp_a; m_pres_stale = m_pres_stale || rv;
      end
      if (rv) begin
        m_pc = rp & ~64'h3; m_slot_v = 0;
        if (m_out) m_out_stale = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    apply_reset();

    // Reset release and first fetch
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("t1_req_valid", 64'(o_v), 64'd1);
    chk("t1_req_addr", o_a, 64'h8000_0000);
    step(0, 0, 0, 0, 1, 32'h0000_0013);
    chk("t1_slot_valid", 64'(inst_valid), 64'd1);
    chk("t1_slot_pc", inst_pc, 64'h8000_0000);
    chk("t1_slot_data", 64'(inst_data), 64'h13);

    // Stall holds the slot and suppresses requests
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 1, 0, 0);
      chk("t2_no_req", 64'(o_v), 64'd0);
      chk("t2_slot_pc", inst_pc, 64'h8000_0000);
    end
    step(0, 0, 0, 1, 0, 0);
    chk("t2_req_addr", o_a, 64'h8000_0004);

    // Redirect while waiting; late response must be discarded
    step(0, 1, 64'h8000_1000, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t3_slot_empty", 64'(inst_valid), 64'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("t3_req_addr", o_a, 64'h8000_1000);

    // Redirect coincident with the response
    step(0, 1, 64'h8000_2000, 0, 1, 32'h1111_1111);
    chk("t4_slot_empty", 64'(inst_valid), 64'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("t4_req_addr", o_a, 64'h8000_2000);

    // Held request survives a redirect and its response is drained
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("t5_hold_addr", o_a, 64'h8000_2000);
    end
    step(0, 1, 64'h8000_3000, 0, 0, 0);
    chk("t5_hold_redir", o_a, 64'h8000_2000);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_hold_valid", 64'(o_v), 64'd1);
    chk("t5_hold_after", o_a, 64'h8000_2000);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'hCAFE_F00D);
    chk("t5_slot_empty", 64'(inst_valid), 64'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("t5_req_addr", o_a, 64'h8000_3000);

    // Back-to-back redirects while draining
    step(0, 1, 64'h100, 0, 0, 0);
    step(0, 1, 64'h200, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h2222_2222);
    chk("t6_slot_empty", 64'(inst_valid), 64'd0);
    step(0, 0, 0, 1, 0, 0);
    chk("t6_req_addr", o_a, 64'h200);
    step(0, 0, 0, 0, 1, 32'h3333_3333);
    chk("t6_slot_pc", inst_pc, 64'h200);

    // PC wrap at the top of the address space
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("wrap_req_top", o_a, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 0, 1, 32'h4444_4444);
    chk("wrap_slot_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    step(0, 0, 0, 1, 0, 0);
    chk("wrap_req_zero", o_a, 64'h0);

    // Random traffic, with an asynchronous reset mid-run
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        st, rv, aok, dok;
      logic [63:0] rp;
      logic [31:0] dat;
      if (cyc == 1500) apply_reset();
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 15) == 0);
      rp  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) << 2);
      rp  = rp & ~64'h3;
      aok = ($urandom_range(0, 2) != 0);
      if (m_out) begin
        dok = (m_lat == 0);
        if (m_lat > 0) m_lat--;
        dat = mem_word(m_out_addr);
      end else begin
        dok = ($urandom_range(0, 7) == 0);
        dat = $urandom;
      end
      step(st, rv, rp, aok, dok, dat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
